axil_master_seq: RTL and testbench
==================================

Name: axil_master_seq

Overview:
- AXI4-Lite initiator that drives the AES register block's AXI slave port (control, mode, key, data-in and IV writes; status and data-out reads).
- Accepts one register command at a time on a valid/ready command port and runs the matching AXI4-Lite write or read.
- Returns the read data and response code on a valid/ready response port.
- Used by the on-chip test sequencer and by the host-bridge bench.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 32, AXI data width; fixed at 32 and checked at elaboration.
- TIMEOUT, 1024, cycles a transaction may wait in one state before the sticky timeout flag is set.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  byte address
- cmd_wdata  in  32  write data
- cmd_wstrb  in  4  write byte strobes
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_rdata  out  32  read data; 0 for writes
- rsp_resp  out  2  BRESP or RRESP
- rsp_write  out  1  response belongs to a write
- m_awaddr  out  ADDR_W  write address
- m_awvalid  out  1  write address valid
- m_awready  in  1  write address ready
- m_wdata  out  32  write data
- m_wstrb  out  4  write strobes
- m_wvalid  out  1  write data valid
- m_wready  in  1  write data ready
- m_bresp  in  2  write response code
- m_bvalid  in  1  write response valid
- m_bready  out  1  write response ready
- m_araddr  out  ADDR_W  read address
- m_arvalid  out  1  read address valid
- m_arready  in  1  read address ready
- m_rdata  in  32  read data
- m_rresp  in  2  read response code
- m_rvalid  in  1  read data valid
- m_rready  out  1  read data ready
- m_awprot, m_arprot  out  3  constant 3'b000
- timeout  out  1  sticky; set when any state exceeds TIMEOUT cycles

Behaviour:
- Reset (sync, active-high): all valid/ready outputs 0, except cmd_ready = 1; all data/address outputs 0; timeout = 0; state IDLE. Reset mid-transaction drops all valids on the next edge and the command is discarded; the bench must reset the slave together with this block.
- All outputs are registered; no combinational path from any input to any output.
- IDLE: cmd_ready = 1. Command handshake captures addr (bits [1:0] forced to 0), wdata, wstrb and write.
  - Write: next state WR_AW_W with m_awvalid = m_wvalid = 1 on the following cycle.
  - Read: next state RD_AR with m_arvalid = 1.
  - cmd_ready drops the cycle after acceptance.
- WR_AW_W: AW and W are handshaked independently.
  - Each valid drops the cycle after its own ready is seen.
  - Tracking flags aw_done and w_done.
  - Both handshaking in the same cycle is legal.
  - When both are done, go to WR_B with m_bready = 1.
  - m_awvalid and m_wvalid are never deasserted before their ready.
- WR_B: on m_bvalid & m_bready, capture m_bresp, set rsp_rdata = 0 and rsp_write = 1, drop m_bready, go to RSP.
- RD_AR: on m_arready, drop m_arvalid, assert m_rready, go to RD_R.
- RD_R: on m_rvalid & m_rready, capture m_rdata and m_rresp, set rsp_write = 0, drop m_rready, go to RSP.
- RSP: rsp_valid = 1, payload held stable until rsp_ready. On the handshake, rsp_valid drops, cmd_ready rises and state returns to IDLE.
- Throughput: minimum 4 cycles per command when the slave responds in 0 wait states.
- Watchdog:
  - 16-bit counter clears on every state change and saturates.
  - When it reaches TIMEOUT, timeout sets and stays set until reset.
  - The transaction is not aborted, to stay AXI-compliant.
- Only one command is in flight at a time; the AW/AR channels are never both active.
- Response codes are passed through unmodified, including SLVERR (2'b10) and DECERR (2'b11).

Decomposition:
- Package axil_pkg:
  - state enum {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP};
  - resp constants OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11;
  - register offset constants: CTRL 0x00, STATUS 0x04, MODE 0x08, KEY0–3 0x10–0x1C, DIN0–3 0x20–0x2C, IV0–3 0x30–0x3C.
- Sub-module: none required; the single FSM plus the watchdog counter is the whole block.

Test Plan:
- Write KEY0 (addr 0x10, data 0x2B7E1516, strb 0xF), slave 0-wait -> m_awaddr = 0x10, m_wdata = 0x2B7E1516, one AW and one W handshake, rsp_valid with rsp_resp = 0, rsp_write = 1, rsp_rdata = 0.
- Read STATUS (0x04), slave returns 0x00000001 after 3 wait cycles -> rsp_rdata = 0x00000001, rsp_resp = 0, rsp_write = 0, m_arvalid held high through the waits.
- Write 0x08 with m_wready 2 cycles before m_awready, then repeat with the order reversed -> each valid drops exactly one cycle after its own ready, exactly one B handshake, and m_bready only after both are done.
- rsp_ready held low 5 cycles after a read of 0x20 -> rsp_valid and payload stable for all 5 cycles, cmd_ready = 0, and a new cmd_valid is not accepted.
- Slave never asserts m_arready, TIMEOUT = 8 -> timeout = 1 on the cycle the count reaches 8, m_arvalid still 1; reset asserted -> all valids 0 and cmd_ready = 1 on the next edge, timeout = 0.
- Read returns RRESP = 2'b11 -> rsp_resp = 2'b11, rsp_rdata = m_rdata passed through, FSM back in IDLE after the response handshake.

Source files
------------

// File: rtl/axil_pkg.sv
// AXI4-Lite initiator shared types: FSM states, response codes, AES register map.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axil_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_AW_W = 3'd1,
    WR_B    = 3'd2,
    RD_AR   = 3'd3,
    RD_R    = 3'd4,
    RSP     = 3'd5
  } state_e;

  // AXI response codes
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  // AES register block byte offsets
  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_STATUS = 8'h04;
  localparam logic [7:0] REG_MODE   = 8'h08;
  localparam logic [7:0] REG_KEY0   = 8'h10;
  localparam logic [7:0] REG_KEY1   = 8'h14;
  localparam logic [7:0] REG_KEY2   = 8'h18;
  localparam logic [7:0] REG_KEY3   = 8'h1C;
  localparam logic [7:0] REG_DIN0   = 8'h20;
  localparam logic [7:0] REG_DIN1   = 8'h24;
  localparam logic [7:0] REG_DIN2   = 8'h28;
  localparam logic [7:0] REG_DIN3   = 8'h2C;
  localparam logic [7:0] REG_IV0    = 8'h30;
  localparam logic [7:0] REG_IV1    = 8'h34;
  localparam logic [7:0] REG_IV2    = 8'h38;
  localparam logic [7:0] REG_IV3    = 8'h3C;

endpackage

// File: rtl/axil_master_seq.sv
// AXI4-Lite initiator: runs one register write or read per command, returns data+resp.
// Latency: 4 cycles per command minimum (accept, AW/W or AR, B or R, response) with a 0-wait slave.
// Backpressure: cmd_ready low while a command is in flight; response held until rsp_ready.
//
// Ports: clk/reset (sync, active-high); cmd_* command port (valid/ready);
// rsp_* response port (valid/ready); m_* AXI4-Lite master channels;
// timeout = sticky watchdog flag, cleared only by reset.
module axil_master_seq
  import axil_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  // command port
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [3:0]        cmd_wstrb,
  // response port
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              rsp_write,
  // AXI4-Lite write channels
  output logic [ADDR_W-1:0] m_awaddr,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [DATA_W-1:0] m_wdata,
  output logic [3:0]        m_wstrb,
  output logic              m_wvalid,
  input  logic              m_wready,
  input  logic [1:0]        m_bresp,
  input  logic              m_bvalid,
  output logic              m_bready,
  // AXI4-Lite read channels
  output logic [ADDR_W-1:0] m_araddr,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic [2:0]        m_awprot,
  output logic [2:0]        m_arprot,
  output logic              timeout
);

  if (DATA_W != 32) begin : g_data_w_check
    $error("axil_master_seq: DATA_W must be 32");
  end

  localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(3);

  state_e            state_q;
  logic              cmd_ready_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic [1:0]        rsp_resp_q;
  logic              rsp_write_q;
  logic [ADDR_W-1:0] awaddr_q;
  logic              awvalid_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wstrb_q;
  logic              wvalid_q;
  logic              bready_q;
  logic [ADDR_W-1:0] araddr_q;
  logic              arvalid_q;
  logic              rready_q;
  logic              aw_done_q;
  logic              w_done_q;
  logic [15:0]       wd_cnt_q;
  logic [15:0]       wd_cnt_d;
  logic              timeout_q;

  // Handshakes, qualified by our own registered valid/ready so they only
  // fire in the state that owns the channel.
  logic cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs, rsp_hs, wr_both_done;
  logic state_chg;

  always_comb begin
    cmd_hs       = cmd_valid & cmd_ready_q;
    aw_hs        = m_awvalid & m_awready;
    w_hs         = m_wvalid & m_wready;
    b_hs         = m_bvalid & bready_q;
    ar_hs        = arvalid_q & m_arready;
    r_hs         = m_rvalid & rready_q;
    rsp_hs       = rsp_valid_q & rsp_ready;
    wr_both_done = (aw_done_q | aw_hs) & (w_done_q | w_hs);

    state_chg = 1'b0;
    case (state_q)
      IDLE:    state_chg = cmd_hs;
      WR_AW_W: state_chg = wr_both_done;
      WR_B:    state_chg = b_hs;
      RD_AR:   state_chg = ar_hs;
      RD_R:    state_chg = r_hs;
      RSP:     state_chg = rsp_hs;
      default: state_chg = 1'b1;
    endcase

    // Watchdog counts dwell time in the current transaction state; idle
    // waiting for a command is not a stall, so IDLE holds it at zero.
    wd_cnt_d = wd_cnt_q;
    if (state_q == IDLE || state_chg) begin
      wd_cnt_d = '0;
    end else if (wd_cnt_q != 16'hFFFF) begin
      wd_cnt_d = wd_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= OKAY;
      rsp_write_q <= 1'b0;
      awaddr_q    <= '0;
      awvalid_q   <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      wd_cnt_q    <= '0;
      timeout_q   <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      // Flag only; the transaction keeps waiting so the bus stays compliant.
      if (32'(wd_cnt_d) >= 32'(TIMEOUT)) begin
        timeout_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (cmd_hs) begin
            cmd_ready_q <= 1'b0;
            if (cmd_write) begin
              awaddr_q  <= cmd_addr & ADDR_MASK;
              wdata_q   <= cmd_wdata;
              wstrb_q   <= cmd_wstrb;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
              state_q   <= WR_AW_W;
            end else begin
              araddr_q  <= cmd_addr & ADDR_MASK;
              arvalid_q <= 1'b1;
              state_q   <= RD_AR;
            end
          end
        end

        WR_AW_W: begin
          // AW and W complete independently, possibly in the same cycle.
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          if (wr_both_done) begin
            bready_q <= 1'b1;
            state_q  <= WR_B;
          end
        end

        WR_B: begin
          if (b_hs) begin
            bready_q    <= 1'b0;
            rsp_resp_q  <= m_bresp;
            rsp_rdata_q <= '0;
            rsp_write_q <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= RSP;
          end
        end

        RD_AR: begin
          if (ar_hs) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_R;
          end
        end

        RD_R: begin
          if (r_hs) begin
            rready_q    <= 1'b0;
            rsp_rdata_q <= m_rdata;
            rsp_resp_q  <= m_rresp;
            rsp_write_q <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RSP;
          end
        end

        RSP: begin
          if (rsp_hs) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign rsp_write = rsp_write_q;
  assign m_awaddr  = awaddr_q;
  assign m_awvalid = awvalid_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = wstrb_q;
  assign m_wvalid  = wvalid_q;
  assign m_bready  = bready_q;
  assign m_araddr  = araddr_q;
  assign m_arvalid = arvalid_q;
  assign m_rready  = rready_q;
  assign m_awprot  = 3'b000;
  assign m_arprot  = 3'b000;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_axil_master_seq.sv
// Directed bench for axil_master_seq; the bench plays the AXI slave cycle by cycle.
// Latency: n/a.
// Backpressure: slave ready/valid and rsp_ready are driven explicitly per step.
module tb_axil_master_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic        m_awvalid, m_awready, m_wvalid, m_wready;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;
  logic        m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;
  logic [2:0]  m_awprot, m_arprot;
  logic        timeout;

  int n_cmp = 0;
  int n_err = 0;

  axil_master_seq #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_write(rsp_write),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awprot(m_awprot), .m_arprot(m_arprot), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Advance one clock edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    cmd_wstrb = strb;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic rsp_take();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    reset = 1'b1;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    rsp_ready = 0;
    m_awready = 0; m_wready = 0; m_bresp = 0; m_bvalid = 0;
    m_arready = 0; m_rdata = 0; m_rresp = 0; m_rvalid = 0;
    tick();
    tick();

    // Reset state
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_awvalid",   32'(m_awvalid), 32'd0);
    chk("rst_wvalid",    32'(m_wvalid), 32'd0);
    chk("rst_arvalid",   32'(m_arvalid), 32'd0);
    chk("rst_bready",    32'(m_bready), 32'd0);
    chk("rst_rready",    32'(m_rready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_timeout",   32'(timeout), 32'd0);
    chk("rst_awaddr",    m_awaddr, 32'd0);
    reset = 1'b0;
    tick();

    // Write KEY0, 0-wait slave
    m_awready = 1; m_wready = 1;
    issue(1'b1, 32'h10, 32'h2B7E1516, 4'hF);
    chk("wr0_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("wr0_awvalid",   32'(m_awvalid), 32'd1);
    chk("wr0_wvalid",    32'(m_wvalid), 32'd1);
    chk("wr0_awaddr",    m_awaddr, 32'h10);
    chk("wr0_wdata",     m_wdata, 32'h2B7E1516);
    chk("wr0_wstrb",     32'(m_wstrb), 32'hF);
    chk("wr0_prot",      32'({m_awprot, m_arprot}), 32'd0);
    tick();
    m_awready = 0; m_wready = 0;
    chk("wr0_aw_drop",   32'(m_awvalid), 32'd0);
    chk("wr0_w_drop",    32'(m_wvalid), 32'd0);
    chk("wr0_bready",    32'(m_bready), 32'd1);
    m_bvalid = 1; m_bresp = 2'b00;
    tick();
    m_bvalid = 0;
    chk("wr0_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("wr0_rsp_resp",  32'(rsp_resp), 32'd0);
    chk("wr0_rsp_write", 32'(rsp_write), 32'd1);
    chk("wr0_rsp_rdata", rsp_rdata, 32'd0);
    chk("wr0_bready_drop", 32'(m_bready), 32'd0);
    rsp_take();
    chk("wr0_rsp_done",  32'(rsp_valid), 32'd0);
    chk("wr0_cmd_ready2", 32'(cmd_ready), 32'd1);

    // Read STATUS, 3 wait cycles on AR
    issue(1'b0, 32'h04, 32'h0, 4'h0);
    chk("rd_araddr", m_araddr, 32'h04);
    for (int i = 0; i < 3; i++) begin
      chk("rd_arvalid_wait", 32'(m_arvalid), 32'd1);
      tick();
    end
    m_arready = 1;
    chk("rd_arvalid_hold", 32'(m_arvalid), 32'd1);
    tick();
    m_arready = 0;
    chk("rd_ar_drop", 32'(m_arvalid), 32'd0);
    chk("rd_rready",  32'(m_rready), 32'd1);
    m_rvalid = 1; m_rdata = 32'h00000001; m_rresp = 2'b00;
    tick();
    m_rvalid = 0;
    chk("rd_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rd_rsp_rdata", rsp_rdata, 32'h00000001);
    chk("rd_rsp_resp",  32'(rsp_resp), 32'd0);
    chk("rd_rsp_write", 32'(rsp_write), 32'd0);
    chk("rd_rready_drop", 32'(m_rready), 32'd0);
    rsp_take();

    // Write MODE (unaligned addr), W ready 2 cycles before AW ready, SLVERR
    issue(1'b1, 32'h0A, 32'h00000003, 4'h1);
    chk("wa_awaddr_align", m_awaddr, 32'h08);
    m_wready = 1;
    tick();
    m_wready = 0;
    chk("wa_w_drop",   32'(m_wvalid), 32'd0);
    chk("wa_aw_hold",  32'(m_awvalid), 32'd1);
    chk("wa_bready0",  32'(m_bready), 32'd0);
    tick();
    chk("wa_aw_hold2", 32'(m_awvalid), 32'd1);
    chk("wa_bready1",  32'(m_bready), 32'd0);
    m_awready = 1;
    tick();
    m_awready = 0;
    chk("wa_aw_drop",  32'(m_awvalid), 32'd0);
    chk("wa_bready",   32'(m_bready), 32'd1);
    m_bvalid = 1; m_bresp = 2'b10;
    tick();
    m_bvalid = 0;
    chk("wa_one_b",    32'(m_bready), 32'd0);
    chk("wa_rsp_resp", 32'(rsp_resp), 32'h2);
    rsp_take();

    // Same write, AW ready 2 cycles before W ready
    issue(1'b1, 32'h08, 32'h00000005, 4'hF);
    m_awready = 1;
    tick();
    m_awready = 0;
    chk("aw_aw_drop",  32'(m_awvalid), 32'd0);
    chk("aw_w_hold",   32'(m_wvalid), 32'd1);
    chk("aw_bready0",  32'(m_bready), 32'd0);
    tick();
    chk("aw_w_hold2",  32'(m_wvalid), 32'd1);
    m_wready = 1;
    tick();
    m_wready = 0;
    chk("aw_w_drop",   32'(m_wvalid), 32'd0);
    chk("aw_bready",   32'(m_bready), 32'd1);
    m_bvalid = 1; m_bresp = 2'b00;
    tick();
    m_bvalid = 0;
    chk("aw_one_b",    32'(m_bready), 32'd0);
    chk("aw_rsp_valid", 32'(rsp_valid), 32'd1);
    rsp_take();

    // Read DIN0, response held off for 5 cycles while a new command waits
    m_arready = 1;
    issue(1'b0, 32'h20, 32'h0, 4'h0);
    tick();
    m_arready = 0;
    m_rvalid = 1; m_rdata = 32'hDEADBEEF; m_rresp = 2'b00;
    tick();
    m_rvalid = 0;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h30; cmd_wdata = 32'h12345678; cmd_wstrb = 4'hF;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
      chk("bp_rsp_write", 32'(rsp_write), 32'd0);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("bp_no_aw",     32'(m_awvalid), 32'd0);
      tick();
    end
    cmd_valid = 0;
    rsp_take();
    chk("bp_rsp_done",  32'(rsp_valid), 32'd0);
    chk("bp_cmd_ready2", 32'(cmd_ready), 32'd1);
    chk("bp_no_aw2",    32'(m_awvalid), 32'd0);

    // Read with DECERR
    m_arready = 1;
    issue(1'b0, 32'h3C, 32'h0, 4'h0);
    tick();
    m_arready = 0;
    m_rvalid = 1; m_rdata = 32'hCAFEF00D; m_rresp = 2'b11;
    tick();
    m_rvalid = 0;
    chk("de_rsp_resp",  32'(rsp_resp), 32'h3);
    chk("de_rsp_rdata", rsp_rdata, 32'hCAFEF00D);
    rsp_take();
    chk("de_idle_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("de_idle_rsp_valid", 32'(rsp_valid), 32'd0);

    // Hung AR channel: watchdog at TIMEOUT = 8
    chk("to_clear_before", 32'(timeout), 32'd0);
    issue(1'b0, 32'h04, 32'h0, 4'h0);
    chk("to_arvalid0", 32'(m_arvalid), 32'd1);
    for (int i = 0; i < 7; i++) tick();
    chk("to_count7", 32'(timeout), 32'd0);
    tick();
    chk("to_count8", 32'(timeout), 32'd1);
    chk("to_arvalid_still", 32'(m_arvalid), 32'd1);
    tick();
    chk("to_sticky", 32'(timeout), 32'd1);
    reset = 1'b1;
    tick();
    chk("to_rst_arvalid",   32'(m_arvalid), 32'd0);
    chk("to_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("to_rst_timeout",   32'(timeout), 32'd0);
    chk("to_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    reset = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
